// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: valid/ready handshake, optional two-entry skid buffer,
// synchronous flush to a bubble and a sticky halt latch that stops intake.
module pipe_stage_elastic #(
   parameter int                DATA_W      = 96,
   parameter int                CTRL_W      = 32,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
   parameter bit                SKID        = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_halt,
   output logic              halted,
   output logic [1:0]        occupancy
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic              main_halt_q,  main_halt_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic              skid_halt_q,  skid_halt_d;
   logic              halted_q,     halted_d;
   logic              in_fire, out_fire, main_load;

   // With the skid buffer, in_ready looks only at registered state.
   assign in_ready  = SKID ? (!skid_valid_q && !halted_q)
                           : ((!main_valid_q || out_ready) && !halted_q);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = main_valid_q && out_ready;
   assign main_load = !main_valid_q || out_fire;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      main_halt_d  = main_halt_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_halt_d  = skid_halt_q;
      halted_d     = halted_q || (in_fire && in_halt);

      if (flush) begin
         main_valid_d = 1'b0;
         main_ctrl_d  = BUBBLE_CTRL;
         main_halt_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_load) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            main_halt_d  = skid_halt_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
            main_halt_d  = in_halt;
         end else begin
            main_valid_d = 1'b0;
            main_ctrl_d  = BUBBLE_CTRL;
            main_halt_d  = 1'b0;
         end
      end else if (SKID && in_fire) begin
         // Main is stalled, so the accepted beat parks in the skid entry.
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
         skid_ctrl_d  = in_ctrl;
         skid_halt_d  = in_halt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ctrl_q  <= BUBBLE_CTRL;
         main_halt_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= BUBBLE_CTRL;
         skid_halt_q  <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         main_halt_q  <= main_halt_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_halt_q  <= skid_halt_d;
         halted_q     <= halted_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;
   assign out_halt  = main_halt_q;
   assign halted    = halted_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: one SKID=1 and one SKID=0 instance, each checked
// every cycle against a small FIFO-style reference model.
module tb_pipe_stage_elastic;

   localparam int         DW  = 16;
   localparam int         CW  = 8;
   localparam logic [7:0] BUB = 8'hE1;

   typedef int iq_t[$];

   logic          clk = 1'b0;
   logic          reset, flush;
   logic          in_valid  [2];
   logic          in_halt   [2];
   logic          out_ready [2];
   logic [DW-1:0] in_data   [2];
   logic [CW-1:0] in_ctrl   [2];

   logic          a_in_ready, a_out_valid, a_out_halt, a_halted;
   logic [DW-1:0] a_out_data;
   logic [CW-1:0] a_out_ctrl;
   logic [1:0]    a_occ;
   logic          b_in_ready, b_out_valid, b_out_halt, b_halted;
   logic [DW-1:0] b_out_data;
   logic [CW-1:0] b_out_ctrl;
   logic [1:0]    b_occ;

   // {in_ready, out_valid, data(16), ctrl(8), out_halt, occupancy(2), halted}
   logic [29:0] obs [2];

   int n_tests = 0;
   int n_fail  = 0;

   int            m_cnt    [2];
   bit            m_halted [2];
   logic [DW-1:0] m_data   [2][2];
   logic [CW-1:0] m_ctrl   [2][2];
   bit            m_hlt    [2][2];

   bit src_on   [2];
   int src_next [2];
   int src_last [2];
   int src_halt [2];
   int log0[$];
   int log1[$];

   always #5 clk = ~clk;

   pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b1)) dut_skid (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid[0]), .in_ready(a_in_ready), .in_data(in_data[0]),
      .in_ctrl(in_ctrl[0]), .in_halt(in_halt[0]),
      .out_valid(a_out_valid), .out_ready(out_ready[0]), .out_data(a_out_data),
      .out_ctrl(a_out_ctrl), .out_halt(a_out_halt), .halted(a_halted), .occupancy(a_occ));

   pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b0)) dut_single (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid[1]), .in_ready(b_in_ready), .in_data(in_data[1]),
      .in_ctrl(in_ctrl[1]), .in_halt(in_halt[1]),
      .out_valid(b_out_valid), .out_ready(out_ready[1]), .out_data(b_out_data),
      .out_ctrl(b_out_ctrl), .out_halt(b_out_halt), .halted(b_halted), .occupancy(b_occ));

   assign obs[0] = {a_in_ready, a_out_valid, a_out_valid ? a_out_data : 16'h0,
                    a_out_ctrl, a_out_halt, a_occ, a_halted};
   assign obs[1] = {b_in_ready, b_out_valid, b_out_valid ? b_out_data : 16'h0,
                    b_out_ctrl, b_out_halt, b_occ, b_halted};

   // Reference: the stage is a FIFO of depth 2 (SKID=1) or 1 (SKID=0).
   function automatic logic model_ready(int k);
      if (m_halted[k]) return 1'b0;
      if (k == 0) return m_cnt[k] < 2;
      return (m_cnt[k] == 0) || out_ready[k];
   endfunction

   function automatic logic [29:0] exp_vec(int k);
      logic v;
      v = m_cnt[k] > 0;
      return {model_ready(k), v, v ? m_data[k][0] : 16'h0, v ? m_ctrl[k][0] : BUB,
              v ? m_hlt[k][0] : 1'b0, 2'(m_cnt[k]), m_halted[k]};
   endfunction

   function automatic iq_t get_log(int k);
      return (k == 0) ? log0 : log1;
   endfunction

   task automatic drive_src();
      for (int k = 0; k < 2; k++) begin
         if (src_on[k]) begin
            in_valid[k] = src_next[k] <= src_last[k];
            in_data[k]  = DW'(src_next[k]);
            in_ctrl[k]  = CW'(src_next[k]);
            in_halt[k]  = src_next[k] == src_halt[k];
         end
      end
   endtask

   task automatic step();
      logic rdy [2];
      bit ifire, ofire;
      for (int k = 0; k < 2; k++) begin
         rdy[k] = model_ready(k);
         if (reset && obs[k][28] && out_ready[k]) begin
            if (k == 0) log0.push_back(int'(obs[k][27:12]));
            else        log1.push_back(int'(obs[k][27:12]));
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            ifire = in_valid[k] && rdy[k];
            ofire = (m_cnt[k] > 0) && out_ready[k];
            if (ifire && in_halt[k]) m_halted[k] = 1'b1;
            if (flush) m_cnt[k] = 0;
            else begin
               if (ofire) begin
                  m_data[k][0] = m_data[k][1];
                  m_ctrl[k][0] = m_ctrl[k][1];
                  m_hlt[k][0]  = m_hlt[k][1];
                  m_cnt[k]--;
               end
               if (ifire) begin
                  m_data[k][m_cnt[k]] = in_data[k];
                  m_ctrl[k][m_cnt[k]] = in_ctrl[k];
                  m_hlt[k][m_cnt[k]]  = in_halt[k];
                  m_cnt[k]++;
               end
            end
            if (src_on[k] && ifire) src_next[k]++;
         end
      end
      @(negedge clk);
      drive_src();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_halted[k] = 1'b0; src_on[k] = 1'b0;
         in_valid[k] = 1'b0; in_halt[k] = 1'b0; out_ready[k] = 1'b0;
         in_data[k] = '0; in_ctrl[k] = '0;
      end
      log0.delete();
      log1.delete();
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   task automatic start_src(int first, int last, int halt_at);
      for (int k = 0; k < 2; k++) begin
         src_on[k] = 1'b1; src_next[k] = first; src_last[k] = last; src_halt[k] = halt_at;
      end
      drive_src();
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         flush = 1'($urandom);
         for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'($urandom); in_halt[k] = 1'($urandom); out_ready[k] = 1'($urandom);
            in_data[k] = DW'($urandom); in_ctrl[k] = CW'($urandom);
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k) || (k == 0 ? a_out_data : b_out_data) !== 16'h0) begin
               n_fail++;
               $display("FAIL reset inst%0d cyc%0d: got %h want %h", k, c, obs[k], exp_vec(k));
            end
         end
         step();
      end
      reset = 1'b1;
      flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b1; in_halt[k] = 1'b0; out_ready[k] = 1'b1;
         in_data[k] = 16'h00A5; in_ctrl[k] = CW'($urandom);
      end
      #1;
      step();
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (obs[k][28] !== 1'b1 || obs[k][27:12] !== 16'h00A5) begin
            n_fail++;
            $display("FAIL reset_first_beat inst%0d: got valid=%b data=%h want valid=1 data=00a5",
                     k, obs[k][28], obs[k][27:12]);
         end
      end
   endtask

   task automatic test_streaming();
      iq_t lg;
      do_reset();
      out_ready[0] = 1'b1; out_ready[1] = 1'b1;
      start_src(0, 19, -1);
      for (int c = 0; c < 24; c++) begin
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k) || obs[k][2:1] > 2'd1) begin
               n_fail++;
               $display("FAIL stream inst%0d cyc%0d: got %h want %h", k, c, obs[k], exp_vec(k));
            end
         end
         step();
      end
      for (int k = 0; k < 2; k++) begin
         lg = get_log(k);
         n_tests++;
         if (lg.size() != 20) begin
            n_fail++;
            $display("FAIL stream_count inst%0d: got %0d beats want 20", k, lg.size());
         end else
            for (int i = 0; i < 20; i++)
               if (lg[i] != i) begin
                  n_fail++;
                  $display("FAIL stream_order inst%0d idx%0d: got %0d want %0d", k, i, lg[i], i);
               end
      end
   endtask

   task automatic test_backpressure();
      iq_t lg;
      do_reset();
      out_ready[0] = 1'b1; out_ready[1] = 1'b1;
      start_src(1, 3, -1);
      for (int c = 0; c < 12; c++) begin
         for (int k = 0; k < 2; k++) out_ready[k] = !(c >= 1 && c <= 3);
         #1;
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL backpressure inst%0d cyc%0d: got %h want %h", k, c, obs[k], exp_vec(k));
            end
         end
         if (c == 2) begin
            n_tests++;
            if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL skid_full: got occ=%0d in_ready=%b want occ=2 in_ready=0", a_occ, a_in_ready);
            end
         end
         if (b_out_valid) begin
            n_tests++;
            if (b_in_ready !== out_ready[1]) begin
               n_fail++;
               $display("FAIL single_ready cyc%0d: got %b want %b", c, b_in_ready, out_ready[1]);
            end
         end
         step();
      end
      for (int k = 0; k < 2; k++) begin
         lg = get_log(k);
         n_tests++;
         if (lg.size() != 3 || lg[0] != 1 || lg[1] != 2 || lg[2] != 3) begin
            n_fail++;
            $display("FAIL backpressure_seq inst%0d: got %p want '{1,2,3}", k, lg);
         end
      end
   endtask

   task automatic test_flush();
      iq_t lg;
      int  dropped [2];
      do_reset();
      start_src(1, 9, -1);
      for (int c = 0; c < 14; c++) begin
         flush = (c == 2) || (c == 6);
         for (int k = 0; k < 2; k++) out_ready[k] = (c >= 4);
         #1;
         if (c == 6)
            for (int k = 0; k < 2; k++) dropped[k] = src_next[k];
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL flush inst%0d cyc%0d: got %h want %h", k, c, obs[k], exp_vec(k));
            end
         end
         if (c == 3 || c == 7) begin
            n_tests++;
            if (a_out_valid !== 1'b0 || a_out_ctrl !== BUB || a_occ !== 2'd0 ||
                b_out_valid !== 1'b0 || b_out_ctrl !== BUB || b_occ !== 2'd0) begin
               n_fail++;
               $display("FAIL flush_bubble cyc%0d: got v=%b/%b ctrl=%h/%h occ=%0d/%0d want 0, %h, 0",
                        c, a_out_valid, b_out_valid, a_out_ctrl, b_out_ctrl, a_occ, b_occ, BUB);
            end
         end
         step();
      end
      flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         lg = get_log(k);
         n_tests++;
         foreach (lg[i])
            if (lg[i] == dropped[k]) begin
               n_fail++;
               $display("FAIL flush_drop inst%0d: got beat %0d on output want it discarded", k, dropped[k]);
            end
      end
   endtask

   task automatic test_halt();
      iq_t lg;
      do_reset();
      out_ready[0] = 1'b1; out_ready[1] = 1'b1;
      start_src(7, 9, 8);
      for (int c = 0; c < 8; c++) begin
         flush = (c == 6);
         #1;
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL halt inst%0d cyc%0d: got %h want %h", k, c, obs[k], exp_vec(k));
            end
            if (obs[k][28] && obs[k][27:12] == 16'd8 && obs[k][3] !== 1'b1) begin
               n_fail++;
               $display("FAIL halt_tag inst%0d: got out_halt=0 want 1 on beat 8", k);
            end
         end
         step();
      end
      flush = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         lg = get_log(k);
         n_tests++;
         if (obs[k][0] !== 1'b1 || obs[k][29] !== 1'b0 || lg.size() != 2 || lg[0] != 7 || lg[1] != 8) begin
            n_fail++;
            $display("FAIL halt_final inst%0d: got halted=%b in_ready=%b log=%p want 1, 0, '{7,8}",
                     k, obs[k][0], obs[k][29], lg);
         end
      end
      do_reset();
      n_tests++;
      if (a_halted !== 1'b0 || b_halted !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_clear: got halted=%b/%b want 0/0", a_halted, b_halted);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         flush = ($urandom_range(15) == 0);
         for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'($urandom); out_ready[k] = ($urandom_range(3) != 0);
            in_data[k] = DW'($urandom); in_ctrl[k] = CW'($urandom); in_halt[k] = 1'b0;
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL random inst%0d cyc%0d: got %h want %h", k, c, obs[k], exp_vec(k));
            end
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_halt();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic pipeline-stage register for the MIPS pipeline, generalising the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. It carries an opaque data payload and a control payload between stages with a valid/ready handshake, and an optional two-entry skid buffer. Synchronous flush inserts a bubble. A sticky halt latch stops intake once a halt-tagged instruction has entered. The hazard unit drives flush and backpressure; the next stage consumes the outputs directly.

## Interface

Parameters:
- DATA_W, 96, data payload width (e.g. RegData1, RegData2, Extendido = 3×32)
- CTRL_W, 32, control payload width (ALUControl, ALUSrc, RegWrite, MemtoReg, MemWrite, MemOp, RegDst, rs/rt/rd)
- BUBBLE_CTRL, {CTRL_W{1'b0}}, control value presented whenever the stage holds no instruction
- SKID, 1, 1 = two-entry skid buffer (no comb ready path); 0 = single entry

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous bubble insertion (clear)
- in_valid  in  1  upstream has a beat
- in_ready  out  1  stage accepts a beat this cycle
- in_data  in  DATA_W  data payload
- in_ctrl  in  CTRL_W  control payload
- in_halt  in  1  beat is a halt instruction
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream consumes output beat
- out_data  out  DATA_W  registered data payload
- out_ctrl  out  CTRL_W  registered control payload
- out_halt  out  1  registered halt tag
- halted  out  1  sticky: a halt beat has been accepted
- occupancy  out  2  number of valid entries (0..2)

## Operation

- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) plus skid entry (SKID=1 only). Each entry holds data, ctrl, halt and a valid bit.
- in_ready:
  - SKID=1: !skid_valid & !halted.
  - SKID=0: (!main_valid | out_ready) & !halted.
- Main update when main is empty or out_fire:
  - If skid is valid, main loads skid.
  - Otherwise, if in_fire, main loads the input.
  - Otherwise main becomes empty.
- Skid update (SKID=1):
  - Loads the input when in_fire while main stays full (main valid & !out_ready).
  - Clears when its contents move to main.
  - Skid never holds a beat while main is empty.
- Order is preserved: FIFO semantics, with no beat lost or duplicated except on flush.
- Bubble rule:
  - Whenever main is empty, out_ctrl = BUBBLE_CTRL and out_halt = 0.
  - out_data holds its last value; it is don't-care.
- Flush has the highest priority:
  - Both entries are invalidated next cycle.
  - out_ctrl ← BUBBLE_CTRL, out_halt ← 0.
  - A beat presented with in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed.
  - Flush does not clear halted.
- Halt:
  - halted sets on the edge where in_fire & in_halt.
  - From the next cycle, in_ready = 0.
  - The halt beat itself propagates normally; entries already stored drain normally.
  - Only reset clears halted.
- occupancy = main_valid + skid_valid.

## Timing

- Reset asserted (reset=0), asynchronously:
  - out_valid=0, out_data=0, out_ctrl=BUBBLE_CTRL, out_halt=0.
  - halted=0, occupancy=0; skid invalid.
  - in_ready evaluates to 1, but no transfer is recorded while reset=0.
- Reset deasserting mid-operation discards all stored beats. The first accept is possible on the first rising edge with reset=1.
- Latency: in_fire at edge N → out_valid=1 after edge N with the same payload. This is 1 cycle when main is empty or being drained.
- Throughput: 1 beat/cycle with out_ready held high, for both SKID values.
- SKID=1:
  - in_ready depends on registered state only.
  - After out_ready falls, one more beat is accepted into skid; in_ready drops the cycle after.
- SKID=0: combinational path from out_ready to in_ready.
- Simultaneous events at one edge:
  - in_fire + out_fire with skid empty: main takes the input; occupancy unchanged.
  - flush + in_fire: flush wins.
  - flush + in_halt accepted: halted still sets, and the halt beat is flushed.
- All outputs are registered except in_ready and occupancy, which are combinational from registered state (and from out_ready when SKID=0).

## Test plan

- Reset values:
  - Stimulus: hold reset=0 with random inputs; then release.
  - Response: outputs at reset values throughout, with out_ctrl=BUBBLE_CTRL; in_data=0x…A5 on the first edge with reset=1 appears on out_data one cycle later with out_valid=1.
- Streaming:
  - Stimulus: 20 back-to-back beats (data=i, ctrl=i) with out_ready=1.
  - Response: out_valid high from cycle 1; outputs i in order; occupancy ≤1.
- Backpressure (SKID=1):
  - Stimulus: stream beats 1,2,3; drop out_ready at the cycle beat 1 is output; hold low 3 cycles.
  - Response: beat 2 is captured in skid; occupancy=2; in_ready=0; after out_ready=1 the outputs are 1,2,3 with no loss or duplicate.
- Flush:
  - Stimulus: occupancy=2 and in_valid=1; pulse flush.
  - Response: next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0; the input beat from the flush cycle never appears.
- Halt:
  - Stimulus: send beats 7, 8 (in_halt=1), 9.
  - Response: 7 and 8 are output, with out_halt=1 on 8; halted=1 after accepting 8; in_ready=0; 9 is never accepted; flush leaves halted=1; only reset clears it.
- SKID=0 variant:
  - Stimulus: rerun the backpressure case.
  - Response: in_ready=out_ready whenever main is valid; no beat is accepted while main is full and out_ready=0.
